// File: rtl/adc02_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc02_spi_scheduler
// Description : Arbitrates the shared peripheral SPI bus between MCU
//               pass-through sessions (framed by CS2) and an internal SPI
//               master that reads one ADC02 frame per DRDY falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module adc02_spi_scheduler #(
  parameter int CLK_DIV   = 4,   // SCLK half-period in clk cycles, >= 2
  parameter int WORD_BITS = 24,  // bits per ADC word, >= 2
  parameter int WORDS     = 5,   // words per frame, >= 2
  parameter int CS_GAP    = 2    // cs_n guard cycles before/after clocking, >= 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mcu_cs_n,
  input  logic                     drdy_n,
  input  logic                     miso,
  output logic                     mcu_grant,
  output logic                     bus_sel,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     cs_n,
  output logic [WORD_BITS-1:0]     word_out,
  output logic [$clog2(WORDS)-1:0] word_idx,
  output logic                     word_valid,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int IDX_W  = $clog2(WORDS);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = $clog2(CS_GAP + 1);
  localparam int TOTAL  = WORDS * WORD_BITS;
  localparam int FALL_W = $clog2(TOTAL + 1);
  localparam int BIT_W  = $clog2(WORD_BITS);

  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [FALL_W-1:0] C_FALL_LAST = FALL_W'(TOTAL);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MCU      = 3'd1,
    S_CS_LEAD  = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_TRAIL = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mcu_sync_q;
  logic [1:0]           drdy_sync_q;
  logic                 drdy_prev_q;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic [FALL_W-1:0]    fall_q, fall_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 word_done_q, word_done_d;
  logic [IDX_W-1:0]     word_cnt_q;
  logic [WORD_BITS-1:0] word_out_q;
  logic [IDX_W-1:0]     word_idx_q;
  logic                 word_valid_q;

  logic mcu_req;
  logic drdy_edge;
  logic busy;
  logic start;

  // Two-flop synchronisers for the asynchronous CS2 and DRDY inputs, plus DRDY history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcu_sync_q  <= 2'b11;
      drdy_sync_q <= 2'b11;
      drdy_prev_q <= 1'b1;
    end else begin
      mcu_sync_q  <= {mcu_sync_q[0], mcu_cs_n};
      drdy_sync_q <= {drdy_sync_q[0], drdy_n};
      drdy_prev_q <= drdy_sync_q[1];
    end
  end

  assign mcu_req   = ~mcu_sync_q[1];
  assign drdy_edge = drdy_prev_q & ~drdy_sync_q[1];
  assign busy      = (state_q == S_CS_LEAD) || (state_q == S_SHIFT) || (state_q == S_CS_TRAIL);
  // A fresh DRDY edge counts as a request in the same cycle, so an MCU request
  // arriving together with it cannot win the arbitration.
  assign start     = (state_q == S_IDLE) && (pending_q || drdy_edge);

  // Next-state logic: arbitration, frame sequencing, SCLK generation and MISO shifting.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    fall_d      = fall_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    word_done_d = 1'b0;
    // At most one frame is ever held back: a start consumes one request.
    pending_d   = start ? (pending_q & drdy_edge) : (pending_q | drdy_edge);
    overrun_d   = drdy_edge & (pending_q | busy);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CS_LEAD;
          gap_d   = '0;
        end else if (mcu_req) begin
          state_d = S_MCU;
        end
      end
      S_MCU: begin
        if (!mcu_req) begin
          state_d = S_IDLE;
        end
      end
      S_CS_LEAD: begin
        if (gap_q == C_GAP_LAST) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;           // first SCLK rise coincides with entering SHIFT
          div_d   = '0;
          fall_d  = '0;
          bit_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == C_DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[WORD_BITS-2:0], miso};
            fall_d  = fall_q + 1'b1;
            if (bit_q == C_BIT_LAST) begin
              bit_d       = '0;
              word_done_d = 1'b1;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else if (fall_q == C_FALL_LAST) begin
            // Low half-period after the final fall has elapsed.
            state_d = S_CS_TRAIL;
            gap_d   = '0;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_CS_TRAIL: begin
        if (gap_q == C_GAP_LAST) begin
          state_d = S_DONE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      gap_q       <= '0;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      fall_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      gap_q       <= gap_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      fall_q      <= fall_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      word_done_q <= word_done_d;
    end
  end

  // Word publication one cycle after its last sampling fall, and the overrun strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_out_q   <= '0;
      word_idx_q   <= '0;
      word_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q    <= overrun_d;
      word_valid_q <= word_done_q;
      if (start) begin
        word_cnt_q <= '0;
      end else if (word_done_q) begin
        word_out_q <= shreg_q;
        word_idx_q <= word_cnt_q;
        word_cnt_q <= (word_cnt_q == C_IDX_LAST) ? '0 : word_cnt_q + 1'b1;
      end
    end
  end

  assign mcu_grant  = (state_q == S_MCU);
  assign bus_sel    = busy;
  assign cs_n       = ~busy;
  assign frame_done = (state_q == S_DONE);
  assign sclk       = sclk_q;
  assign mosi       = 1'b0;
  assign word_out   = word_out_q;
  assign word_idx   = word_idx_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
